// File: rtl/llsc_resv_table_if.sv
// Request/response bundle for the load-linked / store-conditional reservation table.
// One lane per superscalar memory port; lane 0 is oldest in program order.
interface llsc_resv_table_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]       req_valid;
    logic [NUM_PORTS-1:0][1:0]  req_op;
    logic [NUM_PORTS-1:0][63:0] req_addr;
    logic [NUM_PORTS-1:0]       sc_done;
    logic [NUM_PORTS-1:0]       sc_success;

    modport master (
        output req_valid, req_op, req_addr,
        input  sc_done, sc_success
    );

    modport slave (
        input  req_valid, req_op, req_addr,
        output sc_done, sc_success
    );
endinterface

// File: rtl/llsc_resv_table.sv
// LL/SC reservation table: tracks granule reservations from LDL, resolves STC
// success, ages out stale reservations. Ports resolve in program order each cycle.
module llsc_resv_table #(
    parameter int LLSC_SIZE = 4,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_LSB  = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    llsc_resv_table_if.slave               bus,
    output logic [$clog2(LLSC_SIZE+1)-1:0] occupancy,
    output logic                           full
);
    localparam int TW = 64 - ADDR_LSB;
    localparam int AW = $clog2(TIMEOUT + 1);
    localparam int OW = $clog2(LLSC_SIZE + 1);
    localparam logic [AW-1:0] AGE_MAX  = AW'(TIMEOUT);
    localparam logic [OW-1:0] SIZE_CNT = OW'(LLSC_SIZE);

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_LDL = 2'b10,
        OP_STC = 2'b11
    } op_e;

    logic [LLSC_SIZE-1:0] valid_q, valid_d;
    logic [LLSC_SIZE-1:0] good_q, good_d;
    logic [TW-1:0]        tag_q [LLSC_SIZE];
    logic [TW-1:0]        tag_d [LLSC_SIZE];
    logic [AW-1:0]        age_q [LLSC_SIZE];
    logic [AW-1:0]        age_d [LLSC_SIZE];
    logic [LLSC_SIZE-1:0] touched;
    logic [NUM_PORTS-1:0] done_d, success_d;
    logic [OW-1:0]        occ_d;

    logic [TW-1:0] req_tag;
    logic          hit, free_found;
    int            hit_idx, free_idx, victim_idx;
    logic [AW-1:0] victim_age;

    // Granule offset bits never take part in the tag compare.
    logic addr_unused;
    assign addr_unused = ^{1'b0, bus.req_addr[0][ADDR_LSB-1:0]};

    // NOTE: every variable gets a default at the top so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        valid_d    = valid_q;
        good_d     = good_q;
        tag_d      = tag_q;
        age_d      = age_q;
        touched    = '0;
        done_d     = '0;
        success_d  = '0;
        occ_d      = '0;
        req_tag    = '0;
        hit        = 1'b0;
        free_found = 1'b0;
        hit_idx    = 0;
        free_idx   = 0;
        victim_idx = 0;
        victim_age = '0;

        // Reservations that already sat at the age limit are dead before any port looks.
        for (int e = 0; e < LLSC_SIZE; e++) begin
            if (valid_q[e] && age_q[e] == AGE_MAX) valid_d[e] = 1'b0;
        end

        // NOTE: blocking assignments here are deliberate: each port must see the
        // table as already modified by the older ports in the same cycle.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.req_valid[p]) begin
                req_tag = bus.req_addr[p][63:ADDR_LSB];
                hit     = 1'b0;
                hit_idx = 0;
                for (int e = 0; e < LLSC_SIZE; e++) begin
                    if (!hit && valid_d[e] && tag_d[e] == req_tag) begin
                        hit     = 1'b1;
                        hit_idx = e;
                    end
                end

                case (op_e'(bus.req_op[p]))
                    OP_ST: begin
                        for (int e = 0; e < LLSC_SIZE; e++) begin
                            if (valid_d[e] && tag_d[e] == req_tag) valid_d[e] = 1'b0;
                        end
                    end
                    OP_LDL: begin
                        if (hit) begin
                            good_d[hit_idx]  = 1'b1;
                            age_d[hit_idx]   = '0;
                            touched[hit_idx] = 1'b1;
                        end else begin
                            free_found = 1'b0;
                            free_idx   = 0;
                            for (int e = 0; e < LLSC_SIZE; e++) begin
                                if (!free_found && !valid_d[e]) begin
                                    free_found = 1'b1;
                                    free_idx   = e;
                                end
                            end
                            // Oldest entry loses when full; strict compare keeps the lowest index on ties.
                            victim_idx = 0;
                            victim_age = age_d[0];
                            for (int e = 1; e < LLSC_SIZE; e++) begin
                                if (age_d[e] > victim_age) begin
                                    victim_idx = e;
                                    victim_age = age_d[e];
                                end
                            end
                            if (!free_found) free_idx = victim_idx;
                            valid_d[free_idx] = 1'b1;
                            good_d[free_idx]  = 1'b1;
                            tag_d[free_idx]   = req_tag;
                            age_d[free_idx]   = '0;
                            touched[free_idx] = 1'b1;
                        end
                    end
                    OP_STC: begin
                        done_d[p]    = 1'b1;
                        success_d[p] = hit && good_d[hit_idx];
                        if (hit) valid_d[hit_idx] = 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        for (int e = 0; e < LLSC_SIZE; e++) begin
            if (valid_d[e] && !touched[e] && age_d[e] != AGE_MAX) age_d[e] = age_d[e] + AW'(1);
        end

        // A squash wins over everything; STCs still report, but as failures.
        if (flush) begin
            valid_d   = '0;
            good_d    = '0;
            success_d = '0;
        end

        for (int e = 0; e < LLSC_SIZE; e++) begin
            occ_d = occ_d + OW'(valid_d[e]);
        end
    end

    // NOTE: tags and ages are cleared on reset too, so no stale contents are ever observable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q        <= '0;
            good_q         <= '0;
            for (int e = 0; e < LLSC_SIZE; e++) begin
                tag_q[e] <= '0;
                age_q[e] <= '0;
            end
            bus.sc_done    <= '0;
            bus.sc_success <= '0;
            occupancy      <= '0;
            full           <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            good_q         <= good_d;
            tag_q          <= tag_d;
            age_q          <= age_d;
            bus.sc_done    <= done_d;
            bus.sc_success <= success_d;
            occupancy      <= occ_d;
            full           <= (occ_d == SIZE_CNT);
        end
    end
endmodule
